alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit ALU (add/sub/mul/div, 2-bit command, Req/Ack handshake, 16-bit result). It accepts operations from two requesters (e.g. control unit and I/O/DMA path), serialises them onto the single ALU, and returns each 16-bit result with a one-cycle acknowledge. It drives the ALU's Req low between operations so every operation starts on a clean low-to-high Req edge.

## Interface
- `W`, 8: operand width; matches the ALU's operand width.
- `TIMEOUT`, 64: cycles to wait in ISSUE for `alu_ack`. Used only with `ALU_ARB_TIMEOUT_EN`.
- `clk` input 1: clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1 each: requester n requests an operation; level, held until `ackn`.
- `cmd0`, `cmd1` input 2 each: ALU command. 00 add, 01 sub, 10 mul, 11 div.
- `op1_0`, `op2_0`, `op1_1`, `op2_1` input W each: operands.
- `cin0`, `cin1` input 1 each: carry/borrow in.
- `ack0`, `ack1` output 1 each: one-cycle completion pulse.
- `err0`, `err1` output 1 each: qualifies `ackn`; 1 means timed out.
- `result` output 16: last completed result. Valid in the `ackn` cycle and held until the next completion.
- `busy` output 1: high in every state except IDLE.
- `alu_req` output 1: to ALU Req.
- `alu_cmd` output 2: to ALU Cmd.
- `alu_op1`, `alu_op2` output W: to ALU Op1/Op2.
- `alu_cin` output 1: to ALU cin.
- `alu_ack` input 1: from ALU Ack. Must stay high across at least one posedge.
- `alu_out` input 16: from ALU output.

## Operation
- **FSM states:** IDLE, SETUP, ISSUE, DONE.
- **IDLE:**
  - If any `reqn` is high, grant one requester and go to SETUP.
  - On grant, latch the granted requester's cmd/op1/op2/cin into the `alu_*` registers and store its index in `gnt`.
- **SETUP:**
  - `alu_req`=0, operands stable.
  - Next cycle: ISSUE.
- **ISSUE:**
  - `alu_req`=1.
  - Stay until `alu_ack` is sampled high. Then capture `alu_out` into `result` and go to DONE.
- **DONE:**
  - `alu_req`=0, `ack[gnt]`=1 for this single cycle.
  - Next cycle: IDLE.
- **Arbitration:**
  - Round-robin on `last`, which is updated at each grant.
  - If both requests are high, grant the requester ≠ `last`. Otherwise grant whichever is high.
  - `last` resets to 1, so requester 0 wins the first tie.
- **Boundary conditions:**
  - `reqn` still high in the cycle after `ackn` is a new request and is arbitrated normally. With both requests held continuously, grants strictly alternate 0,1,0,1.
  - `reqn` dropped after grant: the operation completes and `ackn` still pulses.
  - `reqn` dropped before grant: nothing happens.
  - Operand changes after grant are ignored, because operands are latched.
  - `alu_ack` high outside ISSUE is ignored.
  - `rst` mid-operation:
    - Return to IDLE next edge.
    - `alu_req`=0; the in-flight operation is discarded with no `ackn`.
    - `result` cleared, `last`=1.
- **Reset values:**
  - All outputs 0: `ack0`/`ack1`/`err0`/`err1`/`busy`/`alu_req`/`alu_cmd`/`alu_op1`/`alu_op2`/`alu_cin`, `result`=16'h0000.
  - `last`=1.

## Timing
- `reqn` sampled at edge k in IDLE → SETUP after k → ISSUE after k+1, with `alu_req` high from k+1.
- `alu_ack` sampled at edge k+1+L (L≥1) → DONE, with `ackn` and the new `result` visible after that edge.
- Minimum request-to-ack latency: 3 cycles. Minimum issue interval: 4 cycles per operation.
- `alu_req` is low for ≥1 full cycle (SETUP, and DONE before it) between consecutive operations.
- `ackn` is never high for more than one cycle. `ack0` and `ack1` are never high together.

## Configuration
- **`ALU_ARB_TIMEOUT_EN` defined:**
  - Counter cleared on ISSUE entry, incremented each ISSUE cycle.
  - When it reaches `TIMEOUT` without `alu_ack`: go to DONE, `result`=16'hFFFF, pulse `ackn` with `errn`=1.
  - `alu_ack` at the same edge as expiry wins, giving a normal completion.
- **Undefined:** no counter; ISSUE waits indefinitely; `err0`/`err1` tied 0.

## Test plan
- Reset, then `req0` with cmd 00, op1 8'h05, op2 8'h03, cin 0; ALU model acks 1 cycle after Req → `ack0` 3 cycles after request, `result`=16'h0008, `err0`=0.
- `req0` and `req1` raised the same cycle and held:
  - Requester 0 is cmd 10, 8'h0C×8'h0A.
  - Requester 1 is cmd 01, 8'h09−8'h04.
  - → grants 0,1,0,1; results alternate 16'h0078 and 16'h0005; `alu_req` drops between every operation.
- Only `req1` active, then `req1` held high after `ack1` → back-to-back grants to 1, one operation every 4 cycles.
- `rst` asserted during ISSUE → next cycle IDLE, `alu_req`=0, no `ack`, `result`=0. The following `req0` is served normally.
- With `ALU_ARB_TIMEOUT_EN`, TIMEOUT=8, ALU never acks → `ack0`=1, `err0`=1, `result`=16'hFFFF, 9 cycles after ISSUE entry. Without the macro → `busy` stays high and no ack is produced.
- Operands changed the cycle after grant → `result` reflects the latched values; `alu_ack` pulse while IDLE → no `ack` output.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles every signal between the ALU arbiter, its two requesters and the
// shared ALU.
//   Requester side : req0/req1, cmd0/cmd1, op1_0/op2_0, op1_1/op2_1,
//                    cin0/cin1 (in to arbiter); ack0/ack1, err0/err1,
//                    result, busy (out of arbiter).
//   ALU side       : alu_req, alu_cmd, alu_op1, alu_op2, alu_cin (out of
//                    arbiter); alu_ack, alu_out (in to arbiter).
// Modports:
//   slave  - the arbiter's view.
//   master - the environment's view (requesters plus the ALU).
interface alu_arbiter_if #(
  parameter int W = 8
);
  logic          req0;
  logic          req1;
  logic [1:0]    cmd0;
  logic [1:0]    cmd1;
  logic [W-1:0]  op1_0;
  logic [W-1:0]  op2_0;
  logic [W-1:0]  op1_1;
  logic [W-1:0]  op2_1;
  logic          cin0;
  logic          cin1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [15:0]   result;
  logic          busy;
  logic          alu_req;
  logic [1:0]    alu_cmd;
  logic [W-1:0]  alu_op1;
  logic [W-1:0]  alu_op2;
  logic          alu_cin;
  logic          alu_ack;
  logic [15:0]   alu_out;

  modport slave (
    input  req0, req1, cmd0, cmd1, op1_0, op2_0, op1_1, op2_1, cin0, cin1,
    input  alu_ack, alu_out,
    output ack0, ack1, err0, err1, result, busy,
    output alu_req, alu_cmd, alu_op1, alu_op2, alu_cin
  );

  modport master (
    output req0, req1, cmd0, cmd1, op1_0, op2_0, op1_1, op2_1, cin0, cin1,
    output alu_ack, alu_out,
    input  ack0, ack1, err0, err1, result, busy,
    input  alu_req, alu_cmd, alu_op1, alu_op2, alu_cin
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-port round-robin arbiter/sequencer for the shared 8-bit ALU. Each
// operation runs IDLE -> SETUP -> ISSUE -> DONE, so alu_req is low for at
// least one full cycle before every rising edge, and the granted requester
// sees a single-cycle ack with the 16-bit result.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - alu_arbiter_if.slave (requester and ALU signals)
// Parameters:
//   W       - operand width
//   TIMEOUT - ISSUE wait limit in cycles (only with ALU_ARB_TIMEOUT_EN)
// Optional feature: define ALU_ARB_TIMEOUT_EN to abort an operation the ALU
// never acknowledges (result 16'hFFFF, errN qualifies the ack).
module alu_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ISSUE, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last;
  logic          r_gnt;
  logic [1:0]    r_cmd;
  logic [W-1:0]  r_op1;
  logic [W-1:0]  r_op2;
  logic          r_cin;
  logic [15:0]   r_result;

  logic          w_any_req;
  logic          w_gnt_sel;
  logic          w_grant;
  logic          w_timeout;
  logic          w_err_flag;

  assign w_any_req = bus.req0 | bus.req1;
  // On a tie the requester that was not served last wins; otherwise the
  // single active requester (req1 high implies index 1).
  assign w_gnt_sel = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_grant   = (r_state == S_IDLE) && w_any_req;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // A real ack at the expiry edge takes priority over the timeout.
  assign w_timeout  = (r_state == S_ISSUE) && !bus.alu_ack &&
                      (r_cnt == CNT_W'(TIMEOUT));
  assign w_err_flag = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end else if ((r_state == S_ISSUE) && !bus.alu_ack && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Decided on the edge that leaves ISSUE, held through DONE.
      if (r_state == S_ISSUE) begin
        r_err <= w_timeout;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_err_flag   = 1'b0;
  assign w_unused_cfg = (TIMEOUT > 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_SETUP;
      S_SETUP: w_state_next = S_ISSUE;
      S_ISSUE: if (bus.alu_ack || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Grant bookkeeping, operand latch and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_cmd    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_cin    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_grant) begin
        r_gnt <= w_gnt_sel;
        r_last <= w_gnt_sel;
        r_cmd <= w_gnt_sel ? bus.cmd1  : bus.cmd0;
        r_op1 <= w_gnt_sel ? bus.op1_1 : bus.op1_0;
        r_op2 <= w_gnt_sel ? bus.op2_1 : bus.op2_0;
        r_cin <= w_gnt_sel ? bus.cin1  : bus.cin0;
      end
      if (r_state == S_ISSUE) begin
        if (bus.alu_ack) begin
          r_result <= bus.alu_out;
        end else if (w_timeout) begin
          r_result <= 16'hFFFF;
        end
      end
    end
  end

  // Outputs decoded from the state register
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.alu_req = (r_state == S_ISSUE);
  assign bus.ack0    = (r_state == S_DONE) && !r_gnt;
  assign bus.ack1    = (r_state == S_DONE) &&  r_gnt;
  assign bus.err0    = (r_state == S_DONE) && !r_gnt && w_err_flag;
  assign bus.err1    = (r_state == S_DONE) &&  r_gnt && w_err_flag;
  assign bus.result  = r_result;
  assign bus.alu_cmd = r_cmd;
  assign bus.alu_op1 = r_op1;
  assign bus.alu_op2 = r_op2;
  assign bus.alu_cin = r_cin;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter with a behavioural ALU that acknowledges
// one cycle after alu_req rises. Expected values are hand-computed constants.
// Define ALU_ARB_TIMEOUT_EN for both DUT and bench to exercise the timeout.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  logic ack_en;
  logic ack_force;

  int   n_checks;
  int   n_bad;

  alu_arbiter_if #(.W(8)) bus ();

  alu_arbiter #(
    .W       (8),
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: responds shortly after each posedge.
  initial begin
    logic [15:0] a;
    logic [15:0] b;
    bus.alu_ack = 1'b0;
    bus.alu_out = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      a = {8'h00, bus.alu_op1};
      b = {8'h00, bus.alu_op2};
      case (bus.alu_cmd)
        2'b00:   bus.alu_out = a + b + {15'h0, bus.alu_cin};
        2'b01:   bus.alu_out = a - b - {15'h0, bus.alu_cin};
        2'b10:   bus.alu_out = a * b;
        default: bus.alu_out = (b == 16'h0) ? 16'hFFFF : a / b;
      endcase
      bus.alu_ack = ack_force | (ack_en & bus.alu_req);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for an ack; n = cycles until ack, limit+1 if none.
  task automatic wait_ack(input int limit, output int n, output logic a0,
                          output logic a1, output logic e, output logic [15:0] res,
                          output logic areq);
    n = 0; a0 = 1'b0; a1 = 1'b0; e = 1'b0; res = 16'h0; areq = 1'b0;
    while (n <= limit) begin
      @(negedge clk);
      n++;
      if (bus.ack0 || bus.ack1) begin
        a0 = bus.ack0; a1 = bus.ack1; e = bus.err0 | bus.err1;
        res = bus.result; areq = bus.alu_req;
        $display("txn: ack0=%0b ack1=%0b err=%0b result=%04h after %0d cycles",
                 a0, a1, e, res, n);
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int          n;
  logic        a0;
  logic        a1;
  logic        e;
  logic [15:0] res;
  logic        areq;

  initial begin
    n_checks  = 0;
    n_bad     = 0;
    ack_en    = 1'b1;
    ack_force = 1'b0;
    rst       = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.cmd0 = 2'b00; bus.cmd1 = 2'b00;
    bus.op1_0 = 8'h00; bus.op2_0 = 8'h00; bus.op1_1 = 8'h00; bus.op2_1 = 8'h00;
    bus.cin0 = 1'b0; bus.cin1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy",    {31'h0, bus.busy},    32'h0);
    check("rst_acks",    {30'h0, bus.ack1, bus.ack0}, 32'h0);
    check("rst_errs",    {30'h0, bus.err1, bus.err0}, 32'h0);
    check("rst_alu_req", {31'h0, bus.alu_req}, 32'h0);
    check("rst_alu_bus", {13'h0, bus.alu_cin, bus.alu_cmd, bus.alu_op1, bus.alu_op2}, 32'h0);
    check("rst_result",  {16'h0, bus.result},  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single add from requester 0
    bus.req0 = 1'b1; bus.cmd0 = 2'b00; bus.op1_0 = 8'h05; bus.op2_0 = 8'h03; bus.cin0 = 1'b0;
    @(negedge clk);
    check("t1_setup_req", {31'h0, bus.alu_req}, 32'h0);
    check("t1_setup_busy", {31'h0, bus.busy}, 32'h1);
    @(negedge clk);
    check("t1_issue_req", {31'h0, bus.alu_req}, 32'h1);
    wait_ack(10, n, a0, a1, e, res, areq);
    bus.req0 = 1'b0;
    check("t1_latency", n + 2, 32'd3);
    check("t1_ack",     {30'h0, a1, a0}, 32'h1);
    check("t1_result",  {16'h0, res}, 32'h0008);
    check("t1_err",     {31'h0, e}, 32'h0);

    // Both requesters held: strict alternation starting with 0
    do_reset();
    bus.req0 = 1'b1; bus.cmd0 = 2'b10; bus.op1_0 = 8'h0C; bus.op2_0 = 8'h0A; bus.cin0 = 1'b0;
    bus.req1 = 1'b1; bus.cmd1 = 2'b01; bus.op1_1 = 8'h09; bus.op2_1 = 8'h04; bus.cin1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(10, n, a0, a1, e, res, areq);
      check($sformatf("t2_gap%0d", i), n, (i == 0) ? 32'd3 : 32'd4);
      check($sformatf("t2_who%0d", i), {30'h0, a1, a0}, (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("t2_res%0d", i), {16'h0, res}, (i % 2 == 0) ? 32'h0078 : 32'h0005);
      check($sformatf("t2_areq%0d", i), {31'h0, areq}, 32'h0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Requester 1 alone, held: back-to-back every 4 cycles
    do_reset();
    bus.req1 = 1'b1; bus.cmd1 = 2'b00; bus.op1_1 = 8'h10; bus.op2_1 = 8'h20; bus.cin1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(10, n, a0, a1, e, res, areq);
      check($sformatf("t3_gap%0d", i), n, (i == 0) ? 32'd3 : 32'd4);
      check($sformatf("t3_who%0d", i), {30'h0, a1, a0}, 32'h2);
      check($sformatf("t3_res%0d", i), {16'h0, res}, 32'h0031);
    end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ISSUE, then a normal request
    ack_en = 1'b0;
    bus.req0 = 1'b1; bus.cmd0 = 2'b11; bus.op1_0 = 8'h64; bus.op2_0 = 8'h05; bus.cin0 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_issue_req",  {31'h0, bus.alu_req}, 32'h1);
    check("t4_issue_cmd",  {30'h0, bus.alu_cmd}, 32'h3);
    check("t4_held_res",   {16'h0, bus.result}, 32'h0031);
    rst = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("t4_rst_busy",   {31'h0, bus.busy}, 32'h0);
    check("t4_rst_req",    {31'h0, bus.alu_req}, 32'h0);
    check("t4_rst_ack",    {30'h0, bus.ack1, bus.ack0}, 32'h0);
    check("t4_rst_res",    {16'h0, bus.result}, 32'h0);
    rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b1;
    wait_ack(10, n, a0, a1, e, res, areq);
    bus.req0 = 1'b0;
    check("t4_lat",  n, 32'd3);
    check("t4_ack",  {30'h0, a1, a0}, 32'h1);
    check("t4_res",  {16'h0, res}, 32'h0014);
    repeat (2) @(negedge clk);

    // ALU never acknowledges
    ack_en = 1'b0;
    bus.req0 = 1'b1; bus.cmd0 = 2'b00; bus.op1_0 = 8'h01; bus.op2_0 = 8'h01; bus.cin0 = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    wait_ack(30, n, a0, a1, e, res, areq);
    bus.req0 = 1'b0;
    check("t5_lat", n, 32'd11);
    check("t5_ack", {30'h0, a1, a0}, 32'h1);
    check("t5_err", {31'h0, e}, 32'h1);
    check("t5_res", {16'h0, res}, 32'hFFFF);
`else
    wait_ack(30, n, a0, a1, e, res, areq);
    check("t5_noack", {30'h0, a1, a0}, 32'h0);
    check("t5_busy",  {31'h0, bus.busy}, 32'h1);
    check("t5_req",   {31'h0, bus.alu_req}, 32'h1);
`endif
    ack_en = 1'b1;
    do_reset();

    // Operands changed after grant, request dropped after grant
    bus.req0 = 1'b1; bus.cmd0 = 2'b00; bus.op1_0 = 8'h05; bus.op2_0 = 8'h03; bus.cin0 = 1'b0;
    @(negedge clk);
    bus.req0 = 1'b0; bus.cmd0 = 2'b10; bus.op1_0 = 8'hAA; bus.op2_0 = 8'h55;
    wait_ack(10, n, a0, a1, e, res, areq);
    check("t6_lat", n, 32'd2);
    check("t6_ack", {30'h0, a1, a0}, 32'h1);
    check("t6_res", {16'h0, res}, 32'h0008);
    @(negedge clk);

    // Stray alu_ack while IDLE
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_stray_ack%0d", i), {30'h0, bus.ack1, bus.ack0}, 32'h0);
      check($sformatf("t6_stray_busy%0d", i), {31'h0, bus.busy}, 32'h0);
    end
    ack_force = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
